uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo_if.sv | 25 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types for the UART receiver: line parity selection
//                and the receive state machine encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Parity carried by each frame.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // Receive state machine states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PAR       = 3'd3,
        STOP      = 3'd4,
        PUSH      = 3'd5,
        WAIT_HIGH = 3'd6
    } rx_state_t;

    // Width of the per-entry error flags {brk, perr, ferr}.
    localparam int c_ERR_W = 3;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Receive-data stream between the UART receiver FIFO and its
//                consumer (valid/ready, first-word-fall-through).
//  Ports       : rdata  - head-of-FIFO data, LSB = first received bit
//                rerr   - head-of-FIFO flags {brk, perr, ferr}
//                rvalid - FIFO holds at least one entry
//                rready - consumer takes the head when rvalid & rready
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rdata;
    logic [c_ERR_W-1:0]   rerr;
    logic                 rvalid;
    logic                 rready;

    modport master (output rdata, output rerr, output rvalid, input rready);
    modport slave  (input rdata, input rerr, input rvalid, output rready);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. A push into a
//                full FIFO is accepted only when a pop happens in the same
//                cycle; a pop from an empty FIFO is ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push, wdata     - write request and data
//                pop             - remove head entry
//                rdata           - head entry (zero while empty)
//                full, empty     - occupancy flags
//                count           - occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL);
    assign count = r_count;

    // A pop frees the slot a simultaneous push into a full FIFO needs.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Gated so the head reads as zero while nothing valid is stored.
    assign rdata = empty ? '0 : r_mem[r_rptr];

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers are exactly c_AW bits wide so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver with input synchroniser, glitch filter,
//                optional parity, 1 or 2 stop bits, break detection and a
//                receive FIFO with sticky overrun flag.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                rxd        - asynchronous serial input, idle high
//                rx_if      - receive stream (rdata, rerr, rvalid, rready)
//                count      - FIFO occupancy
//                oerr       - sticky overrun flag
//                oerr_clr   - clears oerr (a same-cycle overrun wins)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_PER_HALF_BIT = 5208,
    parameter int      DATA_BITS        = 8,
    parameter parity_t PARITY           = PAR_NONE,
    parameter int      STOP_BITS        = 1,
    parameter int      FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    uart_rx_fifo_if.master                rx_if,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          oerr,
    input  logic                          oerr_clr
);
    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_fifo: DATA_BITS must be in 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CLK_PER_HALF_BIT < 2) begin : g_bad_half_bit
        $error("uart_rx_fifo: CLK_PER_HALF_BIT must be >= 2");
    end

    localparam int                 c_CNT_W     = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [2:0]         c_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);
    localparam int                 c_ENT_W     = DATA_BITS + c_ERR_W;

    // ------------------------------------------------------------------
    // Synchroniser and 3-sample agreement filter
    // ------------------------------------------------------------------
    logic [2:0] r_sync;
    logic [2:0] r_filt;
    logic       r_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_filt <= '1;
            r_line <= 1'b1;
        end else begin
            r_sync <= {r_sync[1:0], rxd};
            r_filt <= {r_filt[1:0], r_sync[2]};
            if (r_filt == 3'b000) begin
                r_line <= 1'b0;
            end else if (r_filt == 3'b111) begin
                r_line <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    rx_state_t              r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2:0]             r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bit;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_stop0;
    logic                   r_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_stop0   <= 1'b0;
            r_push    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_line) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end
                end
                START: begin
                    // Mid-start re-check rejects noise that survived the filter.
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_par_bit <= 1'b0;
                        r_state   <= r_line ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_FULL_LAST) begin
                        r_cnt   <= '0;
                        // LSB arrives first, so shift in from the top.
                        r_shift <= {r_line, r_shift[DATA_BITS-1:1]};
                        if (r_bit == c_DATA_LAST) begin
                            r_bit   <= '0;
                            r_state <= (PARITY == PAR_NONE) ? STOP : PAR;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (r_cnt == c_FULL_LAST) begin
                        r_cnt     <= '0;
                        r_par_bit <= r_line;
                        if (PARITY == PAR_ODD) begin
                            r_perr <= ~((^r_shift) ^ r_line);
                        end else begin
                            r_perr <= (^r_shift) ^ r_line;
                        end
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_FULL_LAST) begin
                        r_cnt <= '0;
                        if (!r_line) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bit == 3'd0) begin
                            r_stop0 <= r_line;
                        end
                        if (r_bit == c_STOP_LAST) begin
                            r_bit   <= '0;
                            r_push  <= 1'b1;
                            r_state <= PUSH;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PUSH: begin
                    // A framing error may be a break: wait for the line to
                    // recover so a held-low line yields only one entry.
                    r_state <= r_ferr ? WAIT_HIGH : IDLE;
                end
                WAIT_HIGH: begin
                    if (r_line) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Break: every sampled bit from data through the first stop bit was 0.
    logic               w_brk;
    logic [c_ENT_W-1:0] w_wdata;

    assign w_brk   = (r_shift == '0) && (PARITY == PAR_NONE || !r_par_bit) && !r_stop0;
    assign w_wdata = {w_brk, r_perr, r_ferr, r_shift};

    // ------------------------------------------------------------------
    // Receive FIFO and overrun flag
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;
    logic               r_oerr;

    assign w_pop  = rx_if.rready & ~w_empty;
    assign w_drop = r_push & w_full & ~w_pop;

    sync_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .wdata (w_wdata),
        .pop   (rx_if.rready),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oerr <= 1'b0;
        end else if (w_drop) begin
            r_oerr <= 1'b1;
        end else if (oerr_clr) begin
            r_oerr <= 1'b0;
        end
    end

    assign oerr         = r_oerr;
    assign rx_if.rdata  = w_rdata[DATA_BITS-1:0];
    assign rx_if.rerr   = w_rdata[c_ENT_W-1:DATA_BITS];
    assign rx_if.rvalid = ~w_empty;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Four receivers with
//                different frame formats are driven with directed and
//                random frames; expected FIFO entries come from a queue
//                model built from the bits put on each line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int HB  = 4;
    localparam int BIT = 2 * HB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rxd_v [4];
    logic rdy   [4];
    logic oclr  [4];

    uart_rx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_rx_fifo_if #(.DATA_BITS(7)) if1 ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if2 ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if3 ();

    logic [4:0] cnt0, cnt1, cnt2;
    logic [2:0] cnt3;
    logic       oe0, oe1, oe2, oe3;

    // 8N1 depth 16
    uart_rx_fifo #(.CLK_PER_HALF_BIT(HB), .DATA_BITS(8), .PARITY(PAR_NONE),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd_v[0]), .rx_if(if0),
        .count(cnt0), .oerr(oe0), .oerr_clr(oclr[0]));
    // 7E1 depth 16
    uart_rx_fifo #(.CLK_PER_HALF_BIT(HB), .DATA_BITS(7), .PARITY(PAR_EVEN),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd_v[1]), .rx_if(if1),
        .count(cnt1), .oerr(oe1), .oerr_clr(oclr[1]));
    // 8N2 depth 16
    uart_rx_fifo #(.CLK_PER_HALF_BIT(HB), .DATA_BITS(8), .PARITY(PAR_NONE),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
        .clk(clk), .rst(rst), .rxd(rxd_v[2]), .rx_if(if2),
        .count(cnt2), .oerr(oe2), .oerr_clr(oclr[2]));
    // 8N1 depth 4
    uart_rx_fifo #(.CLK_PER_HALF_BIT(HB), .DATA_BITS(8), .PARITY(PAR_NONE),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .rxd(rxd_v[3]), .rx_if(if3),
        .count(cnt3), .oerr(oe3), .oerr_clr(oclr[3]));

    assign if0.rready = rdy[0];
    assign if1.rready = rdy[1];
    assign if2.rready = rdy[2];
    assign if3.rready = rdy[3];

    // Uniform views: entry = {brk, perr, ferr, data zero-extended to 8}.
    logic [10:0] ent [4];
    logic        vld [4];
    int          occ [4];
    logic        oev [4];
    assign ent[0] = {if0.rerr, if0.rdata};
    assign ent[1] = {if1.rerr, 1'b0, if1.rdata};
    assign ent[2] = {if2.rerr, if2.rdata};
    assign ent[3] = {if3.rerr, if3.rdata};
    assign vld[0] = if0.rvalid;
    assign vld[1] = if1.rvalid;
    assign vld[2] = if2.rvalid;
    assign vld[3] = if3.rvalid;
    assign occ[0] = int'(cnt0);
    assign occ[1] = int'(cnt1);
    assign occ[2] = int'(cnt2);
    assign occ[3] = int'(cnt3);
    assign oev[0] = oe0;
    assign oev[1] = oe1;
    assign oev[2] = oe2;
    assign oev[3] = oe3;

    // Frame formats: data bits, parity (0 none, 1 even, 2 odd), stop bits.
    int nb    [4] = '{8, 7, 8, 8};
    int pm    [4] = '{0, 1, 0, 0};
    int ns    [4] = '{1, 1, 2, 1};
    int depth [4] = '{16, 16, 16, 4};

    // Reference model: one circular queue per receiver plus overrun flag.
    logic [10:0] mq [4][64];
    int          mh [4];
    int          mt [4];
    logic        moe [4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mh[i]  = 0;
            mt[i]  = 0;
            moe[i] = 1'b0;
        end
    endtask

    task automatic model_push(input int i, input logic [10:0] e);
        if (mt[i] - mh[i] >= depth[i]) begin
            moe[i] = 1'b1;
        end else begin
            mq[i][mt[i] % 64] = e;
            mt[i]++;
        end
    endtask

    task automatic drive_bit(input int i, input logic b);
        rxd_v[i] = b;
        repeat (BIT) @(negedge clk);
    endtask

    // Sends one frame on line i and records the entry it should produce.
    task automatic send(input int i, input logic [7:0] d, input bit pflip,
                        input logic s0, input logic s1, input int idle_bits);
        logic [7:0] dm;
        logic       p;
        logic       perr;
        logic       ferr;
        logic       brk;
        dm = d;
        for (int k = nb[i]; k < 8; k++) dm[k] = 1'b0;
        p = ^dm;                      // correct even parity
        if (pm[i] == 2) p = ~p;       // correct odd parity
        if (pflip) p = ~p;
        drive_bit(i, 1'b0);
        for (int k = 0; k < nb[i]; k++) drive_bit(i, dm[k]);
        if (pm[i] != 0) drive_bit(i, p);
        drive_bit(i, s0);
        if (ns[i] == 2) drive_bit(i, s1);
        rxd_v[i] = 1'b1;
        repeat (idle_bits * BIT) @(negedge clk);
        perr = (pm[i] != 0) && pflip;
        ferr = !s0 || (ns[i] == 2 && !s1);
        brk  = (dm == 8'h00) && (pm[i] == 0 || !p) && !s0;
        model_push(i, {brk, perr, ferr, dm});
    endtask

    task automatic pop_check(input int i, input string tag);
        logic [10:0] e;
        if (mh[i] == mt[i]) begin
            check_eq({tag, "_empty_vld"}, 32'(vld[i]), 32'd0);
        end else begin
            e = mq[i][mh[i] % 64];
            check_eq({tag, "_vld"}, 32'(vld[i]), 32'd1);
            check_eq({tag, "_entry"}, 32'(ent[i]), 32'(e));
            mh[i]++;
        end
        rdy[i] = 1'b1;
        @(negedge clk);
        rdy[i] = 1'b0;
    endtask

    task automatic check_state(input int i, input string tag);
        check_eq({tag, "_count"}, 32'(occ[i]), 32'(mt[i] - mh[i]));
        check_eq({tag, "_oerr"},  32'(oev[i]), 32'(moe[i]));
    endtask

    task automatic clear_oerr(input int i);
        oclr[i] = 1'b1;
        @(negedge clk);
        oclr[i] = 1'b0;
        moe[i]  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s0;
        bit         pf;
        int         i;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rxd_v[k] = 1'b1;
            rdy[k]   = 1'b0;
            oclr[k]  = 1'b0;
        end
        model_reset();
        repeat (5) @(negedge clk);

        // Reset state
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_rvalid", 32'(vld[k]), 32'd0);
            check_eq("rst_count",  32'(occ[k]), 32'd0);
            check_eq("rst_oerr",   32'(oev[k]), 32'd0);
            check_eq("rst_entry",  32'(ent[k]), 32'd0);
        end
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);

        // 8N1 0x55: not visible before the stop bit ends, then one entry
        send(0, 8'h55, 1'b0, 1'b1, 1'b1, 0);
        check_eq("n1_pre_push_rvalid", 32'(vld[0]), 32'd0);
        repeat (2 * BIT) @(negedge clk);
        check_eq("n1_count", 32'(occ[0]), 32'd1);
        check_eq("n1_entry", 32'(ent[0]), 32'h055);
        pop_check(0, "n1_pop");
        check_state(0, "n1_after_pop");

        // 7E1 0x41 with wrong then correct parity
        send(1, 8'h41, 1'b1, 1'b1, 1'b1, 2);
        send(1, 8'h41, 1'b0, 1'b1, 1'b1, 2);
        check_eq("e1_count", 32'(occ[1]), 32'd2);
        check_eq("e1_bad_par_entry", 32'(ent[1]), {21'd0, 3'b010, 8'h41});
        pop_check(1, "e1_bad");
        pop_check(1, "e1_good");
        check_state(1, "e1_after");

        // 8N2 0xA3 with second stop bit low -> ferr only
        send(2, 8'hA3, 1'b0, 1'b1, 1'b0, 2);
        check_eq("n2_ferr_entry", 32'(ent[2]), {21'd0, 3'b001, 8'hA3});
        pop_check(2, "n2_ferr");
        // Line held low 40 bit-times: one break entry, nothing more
        rxd_v[2] = 1'b0;
        repeat (40 * BIT) @(negedge clk);
        model_push(2, {3'b101, 8'h00});
        check_eq("brk_count_low", 32'(occ[2]), 32'd1);
        check_eq("brk_entry", 32'(ent[2]), {21'd0, 3'b101, 8'h00});
        rxd_v[2] = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        check_state(2, "brk_after_high");
        pop_check(2, "brk_pop");
        send(2, 8'h5A, 1'b0, 1'b1, 1'b1, 2);
        pop_check(2, "brk_recover");

        // Depth-4 overrun: five frames, fifth dropped
        for (int b = 1; b <= 5; b++) send(3, 8'(b), 1'b0, 1'b1, 1'b1, 2);
        check_eq("ovf_count", 32'(occ[3]), 32'd4);
        check_eq("ovf_oerr",  32'(oev[3]), 32'd1);
        for (int b = 1; b <= 4; b++) begin
            check_eq("ovf_data", 32'(ent[3]), 32'(b));
            pop_check(3, "ovf_pop");
        end
        pop_check(3, "ovf_pop_empty");
        check_state(3, "ovf_drained");
        clear_oerr(3);
        check_eq("ovf_oerr_clr", 32'(oev[3]), 32'd0);

        // Glitches: 2-cycle low and one-half-bit low produce nothing
        rxd_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rxd_v[0] = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        check_eq("glitch2_count", 32'(occ[0]), 32'd0);
        check_eq("glitch2_state", 32'(int'(dut0.r_state)), 32'(int'(IDLE)));
        rxd_v[0] = 1'b0;
        repeat (HB) @(negedge clk);
        rxd_v[0] = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        check_eq("halfbit_count", 32'(occ[0]), 32'd0);
        check_eq("halfbit_rvalid", 32'(vld[0]), 32'd0);
        check_eq("halfbit_state", 32'(int'(dut0.r_state)), 32'(int'(IDLE)));

        // Reset mid-DATA of 0x3C, then a full 0xC3 frame
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rxd_v[0] = 1'b1;
        repeat (HB) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3 * BIT) @(negedge clk);
        check_state(0, "midrst_idle");
        send(0, 8'hC3, 1'b0, 1'b1, 1'b1, 2);
        check_eq("midrst_count", 32'(occ[0]), 32'd1);
        pop_check(0, "midrst_pop");
        check_state(0, "midrst_after");

        // Random frames on the 8N1, 7E1 and depth-4 receivers
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       i = 0;
                1:       i = 1;
                default: i = 3;
            endcase
            d  = 8'($urandom);
            s0 = ($urandom_range(0, 7) != 0);
            pf = (pm[i] != 0) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                d  = 8'h00;
                s0 = 1'b0;
            end
            send(i, d, pf, s0, 1'b1, 2);
            check_state(i, "rnd_after_send");
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_check(i, "rnd_pop");
            check_state(i, "rnd_after_pop");
            if (moe[i] && $urandom_range(0, 1) == 1) begin
                clear_oerr(i);
                check_state(i, "rnd_oerr_clr");
            end
        end

        // Drain everything
        for (int k = 0; k < 4; k++) begin
            while (mh[k] != mt[k]) pop_check(k, "drain");
            check_state(k, "drained");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
